// File: rtl/obi_2_axi_mo.sv
// obi_2_axi_mo: single-clock OBI-to-AXI4 master bridge, up to MAX_OUTSTANDING in-flight
// transactions answered in request order. Define O2A_RESP_REG_EN to register the R/B path.
package obi_2_axi_mo_pkg;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
    } aw_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
    } ar_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_resp_t;
endpackage

module obi_2_axi_mo #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned OBI_ADDRW       = 32,
    parameter int unsigned OBI_DATAW       = 32,
    parameter int unsigned OBI_STRBW       = OBI_DATAW / 8,
    parameter logic [obi_2_axi_mo_pkg::IdWidth-1:0] AXI_ID = '0,
    parameter type aw_chan_t  = obi_2_axi_mo_pkg::aw_chan_t,
    parameter type w_chan_t   = obi_2_axi_mo_pkg::w_chan_t,
    parameter type b_chan_t   = obi_2_axi_mo_pkg::b_chan_t,
    parameter type ar_chan_t  = obi_2_axi_mo_pkg::ar_chan_t,
    parameter type r_chan_t   = obi_2_axi_mo_pkg::r_chan_t,
    parameter type axi_req_t  = obi_2_axi_mo_pkg::axi_req_t,
    parameter type axi_resp_t = obi_2_axi_mo_pkg::axi_resp_t
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic [OBI_ADDRW-1:0] addr_i,
    input  logic                 we_i,
    input  logic [OBI_DATAW-1:0] wdata_i,
    input  logic [OBI_STRBW-1:0] be_i,
    input  logic                 req_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [OBI_DATAW-1:0] rdata_o,
    output logic                 err_o,
    output axi_req_t             axi_req_o,
    input  axi_resp_t            axi_resp_i
);
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CntW-1:0] MaxCnt    = CntW'(MAX_OUTSTANDING);
    localparam logic [PtrW-1:0] LastPtr   = PtrW'(MAX_OUTSTANDING - 1);
    localparam logic [2:0]      AxSize    = 3'($clog2(OBI_STRBW));
    localparam logic [1:0]      BurstIncr = 2'b01;
    localparam logic [1:0]      RespOkay  = 2'b00;

    logic [CntW-1:0]            count_q, count_d;
    logic [PtrW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [MAX_OUTSTANDING-1:0] order_q;
    logic                       ar_valid_q, aw_valid_q, w_valid_q;
    logic [OBI_ADDRW-1:0]       ar_addr_q, aw_addr_q;
    logic [OBI_DATAW-1:0]       w_data_q;
    logic [OBI_STRBW-1:0]       w_strb_q;
    logic                       rvalid_q, err_q;
    logic [OBI_DATAW-1:0]       rdata_q;

    logic                 fifo_empty, head_we, slot_free, accept;
    logic                 r_ready, b_ready, r_hs, b_hs, resp_hs;
    logic                 rsp_valid, rsp_err;
    logic [OBI_DATAW-1:0] rsp_data;
    logic                 unused_resp;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // Order FIFO occupancy equals the outstanding count, so the count doubles as its fill level.
    assign fifo_empty = (count_q == '0);
    assign head_we    = order_q[rd_ptr_q];
    assign slot_free  = we_i ? ~(aw_valid_q | w_valid_q) : ~ar_valid_q;
    assign accept     = req_i & (count_q < MaxCnt) & slot_free;
    assign gnt_o      = accept;

    assign r_ready = ~fifo_empty & ~head_we;
    assign b_ready = ~fifo_empty & head_we;
    assign r_hs    = axi_resp_i.r_valid & r_ready;
    assign b_hs    = axi_resp_i.b_valid & b_ready;
    assign resp_hs = r_hs | b_hs;

    assign unused_resp = ^{axi_resp_i.r.id, axi_resp_i.r.last, axi_resp_i.b.id};

    always_comb begin
        count_d = count_q;
        case ({accept, resp_hs})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            order_q  <= '0;
        end else begin
            count_q <= count_d;
            if (accept) begin
                order_q[wr_ptr_q] <= we_i;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (resp_hs) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // AW and W retire independently; a new write waits until both have drained.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ar_valid_q <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_addr_q  <= '0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
        end else begin
            if (accept && !we_i) begin
                ar_valid_q <= 1'b1;
                ar_addr_q  <= addr_i;
            end else if (axi_resp_i.ar_ready) begin
                ar_valid_q <= 1'b0;
            end
            if (accept && we_i) begin
                aw_valid_q <= 1'b1;
                w_valid_q  <= 1'b1;
                aw_addr_q  <= addr_i;
                w_data_q   <= wdata_i;
                w_strb_q   <= be_i;
            end else begin
                if (axi_resp_i.aw_ready) aw_valid_q <= 1'b0;
                if (axi_resp_i.w_ready)  w_valid_q  <= 1'b0;
            end
        end
    end

    always_comb begin
        axi_req_o           = '0;
        axi_req_o.ar.id     = AXI_ID;
        axi_req_o.ar.addr   = ar_addr_q;
        axi_req_o.ar.len    = '0;
        axi_req_o.ar.size   = AxSize;
        axi_req_o.ar.burst  = BurstIncr;
        axi_req_o.ar_valid  = ar_valid_q;
        axi_req_o.aw.id     = AXI_ID;
        axi_req_o.aw.addr   = aw_addr_q;
        axi_req_o.aw.len    = '0;
        axi_req_o.aw.size   = AxSize;
        axi_req_o.aw.burst  = BurstIncr;
        axi_req_o.aw_valid  = aw_valid_q;
        axi_req_o.w.data    = w_data_q;
        axi_req_o.w.strb    = w_strb_q;
        axi_req_o.w.last    = 1'b1;
        axi_req_o.w_valid   = w_valid_q;
        axi_req_o.r_ready   = r_ready;
        axi_req_o.b_ready   = b_ready;
    end

`ifdef O2A_RESP_REG_EN
    // One-entry buffer drains into the output register every cycle, so it can always accept.
    logic                 buf_valid_q, buf_err_q;
    logic [OBI_DATAW-1:0] buf_data_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            buf_valid_q <= 1'b0;
            buf_err_q   <= 1'b0;
            buf_data_q  <= '0;
        end else begin
            buf_valid_q <= resp_hs;
            buf_err_q   <= (r_hs & (axi_resp_i.r.resp != RespOkay))
                         | (b_hs & (axi_resp_i.b.resp != RespOkay));
            buf_data_q  <= r_hs ? axi_resp_i.r.data : '0;
        end
    end

    assign rsp_valid = buf_valid_q;
    assign rsp_err   = buf_err_q;
    assign rsp_data  = buf_data_q;
`else
    assign rsp_valid = resp_hs;
    assign rsp_err   = (r_hs & (axi_resp_i.r.resp != RespOkay))
                     | (b_hs & (axi_resp_i.b.resp != RespOkay));
    assign rsp_data  = r_hs ? axi_resp_i.r.data : '0;
`endif

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rsp_valid;
            err_q    <= rsp_err;
            rdata_q  <= rsp_data;
        end
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;
endmodule

// File: tb/tb_obi_2_axi_mo.sv
// Self-checking bench for obi_2_axi_mo: directed vector table, corner sequences and a
// randomized run checked against a queue-based transaction model.
module tb_obi_2_axi_mo;
    import obi_2_axi_mo_pkg::*;

    localparam int MaxOut = 4;
`ifdef O2A_RESP_REG_EN
    localparam int Extra = 1;
`else
    localparam int Extra = 0;
`endif

    logic        clk, arst_n, req, we, gnt, rvalid, err;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    axi_req_t    axi_req;
    axi_resp_t   axi_resp;

    int n_checks, n_err;

    obi_2_axi_mo #(.MAX_OUTSTANDING(MaxOut)) dut (
        .clk_i      (clk),
        .arst_ni    (arst_n),
        .addr_i     (addr),
        .we_i       (we),
        .wdata_i    (wdata),
        .be_i       (be),
        .req_i      (req),
        .gnt_o      (gnt),
        .rvalid_o   (rvalid),
        .rdata_o    (rdata),
        .err_o      (err),
        .axi_req_o  (axi_req),
        .axi_resp_i (axi_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } txn_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; } rsp_t;
    typedef struct { int due; logic [31:0] data; bit err; } out_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] quiet_outs();
        return {gnt, axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid, rvalid, err,
                axi_req.r_ready, axi_req.b_ready};
    endfunction

    task automatic idle_inputs();
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        axi_resp = '0;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        idle_inputs();
        arst_n = 1'b0;
        #1;
        check("mid_reset_outs", quiet_outs(), 8'h00);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit ar_d, aw_d, w_d, r_d, b_d, seen;
        ar_d = 0; aw_d = 0; w_d = 0; r_d = 0; b_d = 0; seen = 0;
        @(negedge clk);
        req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata; be = v.be;
        axi_resp = '0;
        axi_resp.ar_ready = 1'b1; axi_resp.aw_ready = 1'b1; axi_resp.w_ready = 1'b1;
        #1;
        check($sformatf("vec%0d_gnt", idx), gnt, 1'b1);
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            req = 1'b0;
            axi_resp.r_valid = ar_d & ~r_d;
            axi_resp.r.data  = v.rdata;
            axi_resp.r.resp  = v.resp;
            axi_resp.r.last  = 1'b1;
            axi_resp.b_valid = aw_d & w_d & ~b_d;
            axi_resp.b.resp  = v.resp;
            #1;
            if (k == 1) begin
                if (v.we) begin
                    check($sformatf("vec%0d_aw_valid", idx), axi_req.aw_valid, 1'b1);
                    check($sformatf("vec%0d_aw_addr", idx), axi_req.aw.addr, v.addr);
                    check($sformatf("vec%0d_aw_len_size_burst", idx),
                          {axi_req.aw.len, axi_req.aw.size, axi_req.aw.burst}, {8'd0, 3'd2, 2'b01});
                    check($sformatf("vec%0d_aw_fixed", idx), {axi_req.aw.id, axi_req.aw.lock,
                          axi_req.aw.cache, axi_req.aw.prot, axi_req.aw.qos, axi_req.aw.region}, 0);
                    check($sformatf("vec%0d_w_valid", idx), axi_req.w_valid, 1'b1);
                    check($sformatf("vec%0d_w_data", idx), axi_req.w.data, v.wdata);
                    check($sformatf("vec%0d_w_strb_last", idx),
                          {axi_req.w.strb, axi_req.w.last}, {v.be, 1'b1});
                    check($sformatf("vec%0d_no_ar", idx), axi_req.ar_valid, 1'b0);
                end else begin
                    check($sformatf("vec%0d_ar_valid", idx), axi_req.ar_valid, 1'b1);
                    check($sformatf("vec%0d_ar_addr", idx), axi_req.ar.addr, v.addr);
                    check($sformatf("vec%0d_ar_len_size_burst", idx),
                          {axi_req.ar.len, axi_req.ar.size, axi_req.ar.burst}, {8'd0, 3'd2, 2'b01});
                    check($sformatf("vec%0d_ar_fixed", idx), {axi_req.ar.id, axi_req.ar.lock,
                          axi_req.ar.cache, axi_req.ar.prot, axi_req.ar.qos, axi_req.ar.region}, 0);
                    check($sformatf("vec%0d_no_aw", idx), {axi_req.aw_valid, axi_req.w_valid}, 0);
                end
            end
            if (axi_req.ar_valid) ar_d = 1;
            if (axi_req.aw_valid) aw_d = 1;
            if (axi_req.w_valid)  w_d = 1;
            if (axi_resp.r_valid && axi_req.r_ready) r_d = 1;
            if (axi_resp.b_valid && axi_req.b_ready) b_d = 1;
            if (rvalid) begin
                seen = 1;
                check($sformatf("vec%0d_latency", idx), k, 3 + Extra);
                check($sformatf("vec%0d_rdata", idx), rdata, v.exp_rdata);
                check($sformatf("vec%0d_err", idx), err, v.exp_err);
            end
        end
        check($sformatf("vec%0d_resp_seen", idx), seen, 1'b1);
        @(negedge clk);
        axi_resp = '0;
        #1;
        check($sformatf("vec%0d_pulse", idx), rvalid, 1'b0);
    endtask

    task automatic test_full();
        int granted, ar_cnt, r_cnt, rcv;
        granted = 0; ar_cnt = 0; r_cnt = 0; rcv = 0;
        idle_inputs();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            req = 1'b1; we = 1'b0; addr = 32'h1000 + 32'(granted * 4);
            axi_resp.ar_ready = 1'b1;
            #1;
            if (axi_req.ar_valid) ar_cnt++;
            if (gnt) granted++;
        end
        check("full_grants", granted, 4);
        check("full_gnt_low", gnt, 1'b0);
        check("full_ar_issued", ar_cnt, 4);
        for (int k = 0; k < 60 && rcv < 5; k++) begin
            @(negedge clk);
            req  = (granted < 5);
            addr = 32'h1000 + 32'(granted * 4);
            axi_resp.r_valid = (ar_cnt > r_cnt);
            axi_resp.r.data  = 32'hD000 + 32'(r_cnt);
            axi_resp.r.resp  = 2'b00;
            axi_resp.r.last  = 1'b1;
            #1;
            if (gnt) begin
                check("full_gnt_after_r", r_cnt > 0, 1'b1);
                granted++;
            end
            if (axi_req.ar_valid) ar_cnt++;
            if (axi_resp.r_valid && axi_req.r_ready) r_cnt++;
            if (rvalid) begin
                check("full_order", rdata, 32'hD000 + 32'(rcv));
                check("full_err", err, 1'b0);
                rcv++;
            end
        end
        check("full_done", rcv, 5);
        check("full_granted", granted, 5);
    endtask

    task automatic test_reorder();
        int n;
        logic [31:0] d[2];
        bit e[2];
        bit r_d, b_d;
        n = 0; r_d = 0; b_d = 0; d[0] = '1; d[1] = '1; e[0] = 1; e[1] = 0;
        idle_inputs();
        axi_resp.ar_ready = 1'b1; axi_resp.aw_ready = 1'b1; axi_resp.w_ready = 1'b1;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h500;
        #1; check("reo_gnt_rd", gnt, 1'b1);
        @(negedge clk);
        we = 1'b1; addr = 32'h600; wdata = 32'h6666; be = 4'hF;
        #1; check("reo_gnt_wr", gnt, 1'b1);
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        axi_resp.b.resp = 2'b10;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            axi_resp.b_valid = 1'b1;
            #1;
            check("reo_b_blocked", axi_req.b_ready, 1'b0);
            check("reo_r_ready", axi_req.r_ready, 1'b1);
            check("reo_no_resp", rvalid, 1'b0);
        end
        for (int k = 0; k < 10 && n < 2; k++) begin
            @(negedge clk);
            axi_resp.r_valid = ~r_d;
            axi_resp.r.data  = 32'hA5A5_0001;
            axi_resp.r.resp  = 2'b00;
            axi_resp.r.last  = 1'b1;
            axi_resp.b_valid = ~b_d;
            #1;
            if (rvalid) begin
                d[n] = rdata; e[n] = err; n++;
            end
            if (!r_d && axi_req.r_ready) r_d = 1;
            else if (!b_d && axi_req.b_ready) begin
                check("reo_b_after_r", r_d, 1'b1);
                b_d = 1;
            end
        end
        check("reo_count", n, 2);
        check("reo_first_data", d[0], 32'hA5A5_0001);
        check("reo_first_err", e[0], 1'b0);
        check("reo_second_data", d[1], 32'h0);
        check("reo_second_err", e[1], 1'b1);
    endtask

    function automatic logic [1:0] rand_resp();
        return ($urandom_range(3) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
    endfunction

    task automatic run_random(input int cycles);
        txn_t ord_q[$], ar_q[$], aw_q[$], w_q[$];
        rsp_t r_pool[$];
        out_t exp_q[$];
        txn_t cur;
        rsp_t rs;
        int aw_tot, w_tot, b_tot;
        bit hold, r_on, b_on, drain, exp_gnt, exp_rr, exp_br;
        logic [1:0] b_resp;
        aw_tot = 0; w_tot = 0; b_tot = 0; hold = 0; r_on = 0; b_on = 0; b_resp = 2'b00;
        cur = '{0, '0, '0, '0};
        idle_inputs();
        for (int c = 0; c < cycles + 300; c++) begin
            drain = (c >= cycles);
            if (drain && !hold && ord_q.size() == 0 && exp_q.size() == 0) break;
            @(negedge clk);
            if (!hold && !drain && $urandom_range(99) < 60) begin
                cur.we = 1'($urandom_range(1)); cur.addr = $urandom;
                cur.wdata = $urandom; cur.be = 4'($urandom_range(15));
                hold = 1;
            end
            req = hold; we = cur.we; addr = cur.addr; wdata = cur.wdata; be = cur.be;
            axi_resp.ar_ready = ($urandom_range(99) < 70);
            axi_resp.aw_ready = ($urandom_range(99) < 70);
            axi_resp.w_ready  = ($urandom_range(99) < 70);
            if (!r_on && r_pool.size() > 0 && $urandom_range(99) < 50) r_on = 1;
            if (!b_on && aw_tot > b_tot && w_tot > b_tot && $urandom_range(99) < 50) begin
                b_on = 1; b_resp = rand_resp();
            end
            axi_resp.r_valid = r_on;
            axi_resp.r.data  = r_on ? r_pool[0].data : '0;
            axi_resp.r.resp  = r_on ? r_pool[0].resp : 2'b00;
            axi_resp.r.last  = 1'b1;
            axi_resp.b_valid = b_on;
            axi_resp.b.resp  = b_resp;
            #1;
            exp_gnt = hold && ord_q.size() < MaxOut &&
                      (cur.we ? (aw_q.size() == 0 && w_q.size() == 0) : ar_q.size() == 0);
            exp_rr = ord_q.size() > 0 && !ord_q[0].we;
            exp_br = ord_q.size() > 0 && ord_q[0].we;
            check("rnd_gnt", gnt, exp_gnt);
            check("rnd_ar_valid", axi_req.ar_valid, ar_q.size() > 0);
            if (ar_q.size() > 0) check("rnd_ar_addr", axi_req.ar.addr, ar_q[0].addr);
            check("rnd_aw_valid", axi_req.aw_valid, aw_q.size() > 0);
            if (aw_q.size() > 0) check("rnd_aw_addr", axi_req.aw.addr, aw_q[0].addr);
            check("rnd_w_valid", axi_req.w_valid, w_q.size() > 0);
            if (w_q.size() > 0)
                check("rnd_w_payload", {axi_req.w.data, axi_req.w.strb}, {w_q[0].wdata, w_q[0].be});
            check("rnd_r_ready", axi_req.r_ready, exp_rr);
            check("rnd_b_ready", axi_req.b_ready, exp_br);
            if (exp_q.size() > 0 && exp_q[0].due == c) begin
                check("rnd_rvalid", rvalid, 1'b1);
                check("rnd_rdata", rdata, exp_q[0].data);
                check("rnd_err", err, exp_q[0].err);
                void'(exp_q.pop_front());
            end else begin
                check("rnd_rvalid_idle", rvalid, 1'b0);
            end
            if (ar_q.size() > 0 && axi_resp.ar_ready) begin
                void'(ar_q.pop_front());
                r_pool.push_back('{$urandom, rand_resp()});
            end
            if (aw_q.size() > 0 && axi_resp.aw_ready) begin void'(aw_q.pop_front()); aw_tot++; end
            if (w_q.size() > 0 && axi_resp.w_ready) begin void'(w_q.pop_front()); w_tot++; end
            if (r_on && exp_rr) begin
                rs = r_pool.pop_front();
                void'(ord_q.pop_front());
                exp_q.push_back('{c + 1 + Extra, rs.data, rs.resp != 2'b00});
                r_on = 0;
            end
            if (b_on && exp_br) begin
                void'(ord_q.pop_front());
                exp_q.push_back('{c + 1 + Extra, 32'h0, b_resp != 2'b00});
                b_tot++;
                b_on = 0;
            end
            if (exp_gnt) begin
                ord_q.push_back(cur);
                if (cur.we) begin aw_q.push_back(cur); w_q.push_back(cur); end
                else ar_q.push_back(cur);
                hold = 0;
            end
        end
        check("rnd_drained", ord_q.size() + exp_q.size() + int'(hold), 0);
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{1'b1, 32'hAB,  32'hBC,       4'hF, 32'h0,        2'b00, 32'h0,        1'b0};
        vecs[1] = '{1'b0, 32'h100, 32'h0,        4'hF, 32'h12E2A,    2'b00, 32'h12E2A,    1'b0};
        vecs[2] = '{1'b0, 32'h200, 32'h0,        4'hF, 32'hDEADBEEF, 2'b10, 32'hDEADBEEF, 1'b1};
        vecs[3] = '{1'b0, 32'h204, 32'h0,        4'hF, 32'h55AA,     2'b00, 32'h55AA,     1'b0};
        vecs[4] = '{1'b1, 32'h300, 32'h11223344, 4'h3, 32'h0,        2'b11, 32'h0,        1'b1};
        vecs[5] = '{1'b1, 32'h304, 32'hCAFEF00D, 4'hC, 32'h0,        2'b00, 32'h0,        1'b0};
        n_checks = 0;
        n_err    = 0;
        idle_inputs();
        arst_n = 1'b0;
        for (int i = 1; i < 70; i++) begin
            #10;
            check("reset_hold", quiet_outs(), 8'h00);
        end
        #10 arst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", quiet_outs(), 8'h00);
        check("reset_rdata", rdata, 32'h0);
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
        mid_reset();
        test_full();
        mid_reset();
        test_reorder();
        mid_reset();
        run_random(2000);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
